// File: rtl/seven_seg_mux.sv
// Four-digit multiplexed 7-segment driver: one frame-synchronous shadow/active register pair, anti-ghost blanking.
// Latency: outputs are registered one cycle after the (digit, count) state; no backpressure (load is a strobe, last one wins).
module seven_seg_mux #(
  parameter int DIV   = 25000,
  parameter int BLANK = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic [3:0]  dig_en,
  input  logic        load,
  output logic [7:0]  io_seg,
  output logic [3:0]  io_sel,
  output logic        frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_t;

  logic [CW-1:0] cnt;
  logic [1:0]    d;
  logic          pending;
  disp_t         shadow;
  disp_t         active;
  disp_t         in_dat;
  logic          slot_end;
  logic          boundary;
  logic [3:0]    nib;
  logic [7:0]    seg_nxt;
  logic [3:0]    sel_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  assign in_dat   = '{value: value, dp: dp, en: dig_en};
  assign slot_end = (cnt == CW'(DIV - 1));
  assign boundary = slot_end && (d == 2'd3);
  assign nib      = active.value[{d, 2'b00} +: 4];

  // The first BLANK cycles of every slot stay dark so the previous digit's pattern never ghosts onto the next.
  always_comb begin
    seg_nxt = 8'hFF;
    sel_nxt = 4'hF;
    if ((cnt >= CW'(BLANK)) && active.en[d]) begin
      sel_nxt    = 4'hF;
      sel_nxt[d] = 1'b0;
      seg_nxt    = ~{active.dp[d], seg7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      d          <= 2'd0;
      pending    <= 1'b0;
      shadow     <= '0;
      active     <= '0;
      io_seg     <= 8'hFF;
      io_sel     <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= slot_end ? '0 : cnt + 1'b1;
      if (slot_end) d <= d + 2'd1;
      io_seg     <= seg_nxt;
      io_sel     <= sel_nxt;
      frame_done <= boundary;
      // Active data only moves at the frame boundary; a load in that very cycle bypasses the shadow.
      if (boundary) begin
        if (load)         active <= in_dat;
        else if (pending) active <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= in_dat;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_mux.sv
// Randomised bench for seven_seg_mux (DIV=8, BLANK=2) against a frame-time behavioural model.
module tb_seven_seg_mux;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  dig_en;
  logic        load;
  logic [7:0]  io_seg;
  logic [3:0]  io_sel;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  seven_seg_mux #(.DIV(8), .BLANK(2)) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .dig_en(dig_en), .load(load),
    .io_seg(io_seg), .io_sel(io_sel), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model: m_t counts cycles since reset release; slot = (t/8)%4, offset = t%8, frame = 32 cycles.
  int          m_t;
  logic        m_pend;
  logic [15:0] m_val, s_val;
  logic [3:0]  m_dp, s_dp, m_en, s_en;
  logic [7:0]  e_seg;
  logic [3:0]  e_sel;
  logic        e_fd;

  always @(posedge clk) begin
    int slot;
    int off;
    logic [3:0] n;
    if (rst) begin
      m_t = 0; m_pend = 1'b0;
      m_val = '0; m_dp = '0; m_en = '0; s_val = '0; s_dp = '0; s_en = '0;
      e_seg = 8'hFF; e_sel = 4'hF; e_fd = 1'b0;
    end else begin
      slot = (m_t / 8) % 4;
      off  = m_t % 8;
      e_seg = 8'hFF;
      e_sel = 4'hF;
      if (off >= 2 && m_en[slot]) begin
        n = m_val[4*slot +: 4];
        e_sel[slot] = 1'b0;
        e_seg = ~{m_dp[slot], seg_tab[n]};
      end
      e_fd = (m_t % 32 == 31);
      if (m_t % 32 == 31) begin
        if (load) begin m_val = value; m_dp = dp; m_en = dig_en; end
        else if (m_pend) begin m_val = s_val; m_dp = s_dp; m_en = s_en; end
        m_pend = 1'b0;
      end else if (load) begin
        s_val = value; s_dp = dp; s_en = dig_en; m_pend = 1'b1;
      end
      m_t = m_t + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, m_t);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("io_seg", {24'd0, io_seg}, {24'd0, e_seg});
      chk("io_sel", {28'd0, io_sel}, {28'd0, e_sel});
      chk("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
      chk("sel_onehot", {31'd0, ($countones(~io_sel) <= 1)}, 32'd1);
    end
  end

  task automatic wait_pos(input int p);
    int guard;
    guard = 0;
    while (m_t % 32 != p && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (m_t % 32 != p) chk("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] p, input logic [3:0] e);
    value = v; dp = p; dig_en = e; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    int first_fd;
    int second_fd;
    int lit;
    rst = 1'b1; load = 1'b0; value = '0; dp = '0; dig_en = '0;

    repeat (3) @(negedge clk);
    chk("rst_seg", {24'd0, io_seg}, 32'hFF);
    chk("rst_sel", {28'd0, io_sel}, 32'hF);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    first_fd = -1; second_fd = -1; lit = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (io_sel != 4'hF || io_seg != 8'hFF) lit++;
      if (frame_done) begin
        if (first_fd < 0) first_fd = m_t;
        else if (second_fd < 0) second_fd = m_t;
      end
    end
    chk("dark_after_reset", lit, 0);
    chk("first_frame_done", first_fd, 32);
    chk("second_frame_done", second_fd, 64);

    wait_pos(10);
    do_load(16'h1234, 4'b0001, 4'hF);
    wait_pos(20);
    chk("no_tear_sel", {28'd0, io_sel}, 32'hF);
    wait_pos(5);
    chk("dig0_sel", {28'd0, io_sel}, 32'hE);
    chk("dig0_seg", {24'd0, io_seg}, 32'h19);
    wait_pos(30);
    chk("dig3_sel", {28'd0, io_sel}, 32'h7);
    chk("dig3_seg", {24'd0, io_seg}, 32'hF9);

    wait_pos(0);
    lit = 0;
    for (int i = 0; i < 32; i++) begin
      if (io_sel != 4'hF) lit++;
      @(negedge clk);
    end
    chk("lit_per_frame", lit, 24);

    wait_pos(5);
    do_load(16'hFFFF, 4'b0000, 4'hF);
    wait_pos(12);
    do_load(16'h0000, 4'b0000, 4'hF);
    wait_pos(5);
    chk("last_wins_seg", {24'd0, io_seg}, 32'hC0);
    wait_pos(31);
    do_load(16'hAAAA, 4'b0000, 4'hF);
    wait_pos(5);
    chk("bypass_seg", {24'd0, io_seg}, 32'h88);

    wait_pos(10);
    do_load(16'h8888, 4'b0000, 4'b0101);
    wait_pos(5);
    chk("en0_seg", {24'd0, io_seg}, 32'h80);
    chk("en0_sel", {28'd0, io_sel}, 32'hE);
    wait_pos(13);
    chk("en1_dark", {28'd0, io_sel}, 32'hF);
    wait_pos(21);
    chk("en2_sel", {28'd0, io_sel}, 32'hB);
    chk("en2_seg", {24'd0, io_seg}, 32'h80);
    wait_pos(29);
    chk("en3_dark", {28'd0, io_sel}, 32'hF);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0 || (m_t % 32 == 31 && $urandom_range(1) == 0)) begin
        value = 16'($urandom); dp = 4'($urandom); dig_en = 4'($urandom); load = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;

    wait_pos(20);
    rst = 1'b1;
    do_load(16'h1111, 4'hF, 4'hF);
    rst = 1'b0;
    chk("midrst_seg", {24'd0, io_seg}, 32'hFF);
    chk("midrst_sel", {28'd0, io_sel}, 32'hF);
    first_fd = -1; lit = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (io_sel != 4'hF) lit++;
      if (frame_done && first_fd < 0) first_fd = m_t;
    end
    chk("midrst_fd", first_fd, 32);
    chk("midrst_dark", lit, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
